dmem_lsu: RTL and testbench



---
 rtl/dmem_lsu.sv | 174 +++++++++++++++++
 tb/tb_dmem_lsu.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_lsu.sv
// Byte-addressable RV32 data memory with load/store alignment, lane masking and load extension.
// Optional: define DMEM_LSU_MISALIGN_TRAP_EN to flag misaligned accesses and suppress them.
module dmem_lsu #(
  parameter int unsigned DEPTH        = 256,
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned ADDR_W       = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_misalign,
  output logic              rsp_illegal
);

  localparam int unsigned IDX_W = $clog2(DEPTH);

  logic             accept;
  logic [IDX_W-1:0] idx;
  logic             legal;
  logic             mis_flag;
  logic             err;
  logic [1:0]       off;
  logic [3:0]       mask;
  logic [31:0]      wdat;
  logic             wr_en;

  assign req_ready = ~reset;
  assign accept    = req_valid & ~reset;
  assign idx       = req_addr[IDX_W+1:2];

  generate
    if (ADDR_W > IDX_W + 2) begin : g_upper
      logic unused_addr;
      assign unused_addr = ^req_addr[ADDR_W-1:IDX_W+2];
    end
  endgenerate

  // Request decode: legality, effective byte offset, lane mask and replicated store data
  always_comb begin
    legal    = 1'b0;
    mis_flag = 1'b0;
    off      = req_addr[1:0];
    mask     = 4'b0000;
    wdat     = req_wdata;
    case (req_funct3)
      3'b000, 3'b001, 3'b010: legal = 1'b1;
      3'b100, 3'b101:         legal = ~req_we;
      default:                legal = 1'b0;
    endcase
`ifdef DMEM_LSU_MISALIGN_TRAP_EN
    mis_flag = legal & (((req_funct3[1:0] == 2'b01) & req_addr[0]) |
                        ((req_funct3[1:0] == 2'b10) & (req_addr[1:0] != 2'b00)));
`else
    // Without the trap, misaligned halves/words are silently rounded down
    if (req_funct3[1:0] == 2'b01) off = {req_addr[1], 1'b0};
    if (req_funct3[1:0] == 2'b10) off = 2'b00;
`endif
    case (req_funct3[1:0])
      2'b00: begin
        mask = 4'b0001 << off;
        wdat = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        mask = off[1] ? 4'b1100 : 4'b0011;
        wdat = {2{req_wdata[15:0]}};
      end
      2'b10:   mask = 4'b1111;
      default: mask = 4'b0000;
    endcase
  end

  assign err   = ~legal | mis_flag;
  assign wr_en = accept & req_we & ~err;

  logic [31:0] mem [DEPTH];
  logic [31:0] rd_word;

  // RAM: byte-lane writes and registered read, no reset on contents
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (mask[b]) mem[idx][8*b +: 8] <= wdat[8*b +: 8];
      end
    end
    if (accept) rd_word <= mem[idx];
  end

  logic       v1;
  logic       ld1;
  logic [2:0] f3_1;
  logic [1:0] off_1;
  logic       mis1;
  logic       ill1;

  // First response stage: side-band needed to pick and extend the load data
  always_ff @(posedge clk) begin
    if (reset) begin
      v1    <= 1'b0;
      ld1   <= 1'b0;
      f3_1  <= 3'b000;
      off_1 <= 2'b00;
      mis1  <= 1'b0;
      ill1  <= 1'b0;
    end else begin
      v1 <= accept;
      if (accept) begin
        ld1   <= ~req_we & ~err;
        f3_1  <= req_funct3;
        off_1 <= off;
        mis1  <= mis_flag;
        ill1  <= ~legal;
      end
    end
  end

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] ext;
  logic [31:0] s1_data;

  assign byte_sel = rd_word[{off_1, 3'b000} +: 8];
  assign half_sel = off_1[1] ? rd_word[31:16] : rd_word[15:0];

  always_comb begin
    case (f3_1[1:0])
      2'b00:   ext = {{24{~f3_1[2] & byte_sel[7]}}, byte_sel};
      2'b01:   ext = {{16{~f3_1[2] & half_sel[15]}}, half_sel};
      default: ext = rd_word;
    endcase
  end

  assign s1_data = (v1 & ld1) ? ext : 32'h0;

  generate
    if (READ_LATENCY == 2) begin : g_lat2
      logic        v2;
      logic [31:0] d2;
      logic        m2;
      logic        i2;

      always_ff @(posedge clk) begin
        if (reset) begin
          v2 <= 1'b0;
          d2 <= 32'h0;
          m2 <= 1'b0;
          i2 <= 1'b0;
        end else begin
          v2 <= v1;
          d2 <= s1_data;
          m2 <= v1 & mis1;
          i2 <= v1 & ill1;
        end
      end

      assign rsp_valid    = v2;
      assign rsp_rdata    = d2;
      assign rsp_misalign = m2;
      assign rsp_illegal  = i2;
    end else begin : g_lat1
      assign rsp_valid    = v1;
      assign rsp_rdata    = s1_data;
      assign rsp_misalign = v1 & mis1;
      assign rsp_illegal  = v1 & ill1;
    end
  endgenerate

endmodule

// File: tb/tb_dmem_lsu.sv
// Bench for dmem_lsu: latency-1 and latency-2 instances driven in parallel against a byte-array model.
module tb_dmem_lsu;

  localparam int unsigned DEPTH = 256;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;

  logic        ready1, ready2;
  logic        r1_valid, r1_mis, r1_ill;
  logic        r2_valid, r2_mis, r2_ill;
  logic [31:0] r1_rdata, r2_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  dmem_lsu #(.DEPTH(DEPTH), .READ_LATENCY(1), .ADDR_W(32)) u_dut1 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(ready1),
    .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(r1_valid), .rsp_rdata(r1_rdata), .rsp_misalign(r1_mis), .rsp_illegal(r1_ill)
  );

  dmem_lsu #(.DEPTH(DEPTH), .READ_LATENCY(2), .ADDR_W(32)) u_dut2 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(ready2),
    .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(r2_valid), .rsp_rdata(r2_rdata), .rsp_misalign(r2_mis), .rsp_illegal(r2_ill)
  );

  // Reference model: flat byte array, expected responses for 1 and 2 cycle latency
  logic [7:0]  mm [4*DEPTH];
  logic [34:0] e1 = '0;
  logic [34:0] e2 = '0;

  always @(posedge clk) begin : model
    int unsigned a, n;
    logic legal, mis, bad, mflag;
    logic [31:0] v;
    if (reset) begin
      e1 = '0;
      e2 = '0;
    end else begin
      e2 = e1;
      e1 = '0;
      if (req_valid) begin
        a = req_addr % (4 * DEPTH);
        n = 1 << req_funct3[1:0];
        legal = (req_funct3 <= 3'd2) || (!req_we && (req_funct3 == 3'd4 || req_funct3 == 3'd5));
        mis = legal && ((a % n) != 0);
`ifdef DMEM_LSU_MISALIGN_TRAP_EN
        bad = !legal || mis;
        mflag = mis;
`else
        a = a - (a % n);
        bad = !legal;
        mflag = 1'b0;
`endif
        v = 32'h0;
        if (!bad) begin
          if (req_we) begin
            for (int i = 0; i < int'(n); i++) mm[a + i] = req_wdata[8*i +: 8];
          end else begin
            for (int i = 0; i < int'(n); i++) v = v | (32'(mm[a + i]) << (8 * i));
            if (n < 4 && !req_funct3[2] && v[8*n - 1]) v = v | (32'hFFFF_FFFF << (8 * n));
          end
        end
        e1 = {1'b1, v, mflag, !legal};
      end
    end
  end

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        mis;
    logic        ill;
  } op_t;

  function automatic op_t mk(logic we, logic [2:0] f3, logic [31:0] addr, logic [31:0] wd,
                             logic [31:0] rd, logic mis, logic ill);
    op_t o;
    o.we = we; o.f3 = f3; o.addr = addr; o.wd = wd; o.rd = rd; o.mis = mis; o.ill = ill;
    return o;
  endfunction

  task automatic drive(input logic v, input logic we, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd);
    req_valid  = v;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      n_checks++;
      if ({ready1, ready2} !== 2'b00) begin
        n_fail++;
        $display("FAIL reset_ready cycle %0d: got %b want 00", c, {ready1, ready2});
      end
      n_checks++;
      if ({r1_valid, r1_rdata, r1_mis, r1_ill, r2_valid, r2_rdata, r2_mis, r2_ill} !== '0) begin
        n_fail++;
        $display("FAIL reset_outputs cycle %0d: got r1=%b/%h r2=%b/%h want all zero",
                 c, r1_valid, r1_rdata, r2_valid, r2_rdata);
      end
    end
    reset = 1'b0;
    #1;
    n_checks++;
    if ({ready1, ready2} !== 2'b11) begin
      n_fail++;
      $display("FAIL ready_after_reset: got %b want 11", {ready1, ready2});
    end
  endtask

  // Test-plan sequences issued back to back; expectations are hand-derived constants
  task automatic test_directed();
    op_t tbl[$];
    logic [34:0] exp;
    tbl.push_back(mk(1, 3'b010, 32'h10,  32'hDEADBEEF, 32'h0,        0, 0));
    tbl.push_back(mk(0, 3'b010, 32'h10,  32'h0,        32'hDEADBEEF, 0, 0));
    tbl.push_back(mk(1, 3'b000, 32'h13,  32'h80,       32'h0,        0, 0));
    tbl.push_back(mk(0, 3'b000, 32'h13,  32'h0,        32'hFFFFFF80, 0, 0));
    tbl.push_back(mk(0, 3'b100, 32'h13,  32'h0,        32'h00000080, 0, 0));
    tbl.push_back(mk(0, 3'b010, 32'h10,  32'h0,        32'h80ADBEEF, 0, 0));
    tbl.push_back(mk(1, 3'b001, 32'h12,  32'h1234,     32'h0,        0, 0));
    tbl.push_back(mk(0, 3'b001, 32'h12,  32'h0,        32'h00001234, 0, 0));
    tbl.push_back(mk(0, 3'b010, 32'h10,  32'h0,        32'h1234BEEF, 0, 0));
    tbl.push_back(mk(0, 3'b101, 32'h10,  32'h0,        32'h0000BEEF, 0, 0));
    tbl.push_back(mk(1, 3'b010, 32'h20,  32'hA5A5A5A5, 32'h0,        0, 0));
    tbl.push_back(mk(0, 3'b010, 32'h20,  32'h0,        32'hA5A5A5A5, 0, 0));
    tbl.push_back(mk(0, 3'b010, 32'h420, 32'h0,        32'hA5A5A5A5, 0, 0));
    tbl.push_back(mk(1, 3'b010, 32'hF424, 32'h11223344, 32'h0,       0, 0));
    tbl.push_back(mk(1, 3'b000, 32'h25,  32'hFFFFFF77, 32'h0,        0, 0));
    tbl.push_back(mk(0, 3'b010, 32'h24,  32'h0,        32'h11227744, 0, 0));
    tbl.push_back(mk(0, 3'b001, 32'h26,  32'h0,        32'h00001122, 0, 0));
    tbl.push_back(mk(0, 3'b000, 32'h25,  32'h0,        32'h00000077, 0, 0));
`ifdef DMEM_LSU_MISALIGN_TRAP_EN
    tbl.push_back(mk(0, 3'b010, 32'h22,  32'h0,        32'h0,        1, 0));
    tbl.push_back(mk(1, 3'b001, 32'h21,  32'hBEEF,     32'h0,        1, 0));
    tbl.push_back(mk(0, 3'b010, 32'h20,  32'h0,        32'hA5A5A5A5, 0, 0));
`else
    tbl.push_back(mk(0, 3'b010, 32'h22,  32'h0,        32'hA5A5A5A5, 0, 0));
    tbl.push_back(mk(1, 3'b001, 32'h21,  32'hBEEF,     32'h0,        0, 0));
    tbl.push_back(mk(0, 3'b010, 32'h20,  32'h0,        32'hA5A5BEEF, 0, 0));
`endif
    tbl.push_back(mk(0, 3'b011, 32'h20,  32'h0,        32'h0,        0, 1));
    tbl.push_back(mk(1, 3'b100, 32'h20,  32'h0,        32'h0,        0, 1));
    tbl.push_back(mk(1, 3'b110, 32'h20,  32'h0,        32'h0,        0, 1));
`ifdef DMEM_LSU_MISALIGN_TRAP_EN
    tbl.push_back(mk(0, 3'b010, 32'h20,  32'h0,        32'hA5A5A5A5, 0, 0));
`else
    tbl.push_back(mk(0, 3'b010, 32'h20,  32'h0,        32'hA5A5BEEF, 0, 0));
`endif

    for (int i = 0; i <= tbl.size(); i++) begin
      if (i < tbl.size()) drive(1'b1, tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wd);
      else drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
      @(posedge clk); #1;
      n_checks++;
      if (i < tbl.size()) exp = {1'b1, tbl[i].rd, tbl[i].mis, tbl[i].ill};
      else exp = '0;
      if ({r1_valid, r1_rdata, r1_mis, r1_ill} !== exp) begin
        n_fail++;
        $display("FAIL directed_lat1[%0d]: got v=%b d=%h m=%b i=%b want v=%b d=%h m=%b i=%b",
                 i, r1_valid, r1_rdata, r1_mis, r1_ill, exp[34], exp[33:2], exp[1], exp[0]);
      end
      if (i > 0) begin
        exp = {1'b1, tbl[i-1].rd, tbl[i-1].mis, tbl[i-1].ill};
        n_checks++;
        if ({r2_valid, r2_rdata, r2_mis, r2_ill} !== exp) begin
          n_fail++;
          $display("FAIL directed_lat2[%0d]: got v=%b d=%h m=%b i=%b want v=%b d=%h m=%b i=%b",
                   i - 1, r2_valid, r2_rdata, r2_mis, r2_ill, exp[34], exp[33:2], exp[1], exp[0]);
        end
      end
    end
    @(posedge clk); #1;
    n_checks++;
    if (r2_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL directed_lat2_idle: got rsp_valid=%b want 0", r2_valid);
    end
  endtask

  // Random traffic over a 16-word window with aliasing upper address bits
  task automatic test_random();
    logic [2:0] f3;
    for (int w = 0; w < 16; w++) begin
      drive(1'b1, 1'b1, 3'b010, 32'(w * 4), $urandom());
      @(posedge clk); #1;
    end
    for (int c = 0; c < 400; c++) begin
      if (($urandom() % 6) == 0) f3 = 3'($urandom() % 8);
      else f3 = ($urandom() % 2 == 0) ? 3'($urandom() % 3) : 3'(4 + $urandom() % 2);
      drive(($urandom() % 8) != 0, 1'($urandom() % 2), f3,
            $urandom() & 32'hFFFF_FC3F, $urandom());
      @(posedge clk); #1;
      n_checks++;
      if ({r1_valid, r1_rdata, r1_mis, r1_ill} !== e1) begin
        n_fail++;
        $display("FAIL random_lat1 cycle %0d: got v=%b d=%h m=%b i=%b want v=%b d=%h m=%b i=%b",
                 c, r1_valid, r1_rdata, r1_mis, r1_ill, e1[34], e1[33:2], e1[1], e1[0]);
      end
      n_checks++;
      if ({r2_valid, r2_rdata, r2_mis, r2_ill} !== e2) begin
        n_fail++;
        $display("FAIL random_lat2 cycle %0d: got v=%b d=%h m=%b i=%b want v=%b d=%h m=%b i=%b",
                 c, r2_valid, r2_rdata, r2_mis, r2_ill, e2[34], e2[33:2], e2[1], e2[0]);
      end
    end
    drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    @(posedge clk); #1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_midflight();
    drive(1'b1, 1'b0, 3'b010, 32'h10, 32'h0);
    @(posedge clk); #1;
    drive(1'b1, 1'b0, 3'b010, 32'h20, 32'h0);
    @(posedge clk); #1;
    reset = 1'b1;
    drive(1'b1, 1'b0, 3'b010, 32'h24, 32'h0);
    #1;
    n_checks++;
    if ({ready1, ready2} !== 2'b00) begin
      n_fail++;
      $display("FAIL midflight_ready: got %b want 00", {ready1, ready2});
    end
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      if (c == 1) begin
        reset = 1'b0;
        drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
      end
      n_checks++;
      if ({r1_valid, r2_valid} !== 2'b00) begin
        n_fail++;
        $display("FAIL midflight_no_rsp cycle %0d: got %b want 00", c, {r1_valid, r2_valid});
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_reset_midflight();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
